// File: rtl/axis_sync_fifo_lvl.sv
// axis_sync_fifo_lvl: synchronous AXI-Stream FIFO with fill-level reporting,
// runtime almost-full/almost-empty thresholds and a synchronous flush.
// The storage is a RAM array followed by a registered output stage. fill_level
// counts both, so the FIFO holds up to 2**mem_width words in total.
// Optional feature: define AXIS_FIFO_DROP_EN to keep s_axis_tready high and
// discard (and count) writes that arrive while the FIFO is full.
module axis_sync_fifo_lvl #(
    parameter int mem_width = 4,
    parameter int bus_width = 16
) (
    input  logic                 axis_clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [bus_width-1:0] s_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [bus_width-1:0] m_axis_tdata,
    input  logic [mem_width:0]   af_thresh,
    input  logic [mem_width:0]   ae_thresh,
    output logic [mem_width:0]   fill_level,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [15:0]          drop_count
);

    localparam int DEPTH = 2 ** mem_width;
    localparam logic [mem_width:0] DEPTH_L = (mem_width + 1)'(DEPTH);
    localparam logic [mem_width:0] ONE_L   = (mem_width + 1)'(1);

    logic [bus_width-1:0] mem_q [DEPTH];

    logic [mem_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [mem_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [mem_width:0]   fill_q, fill_d;
    logic [mem_width:0]   ram_cnt;
    logic                 out_valid_q, out_valid_d;
    logic [bus_width-1:0] out_data_q;
    logic                 rdy_q;
    logic                 af_q, af_d;
    logic                 ae_q, ae_d;
    logic                 full;
    logic                 wr_en;
    logic                 rd_en;
    logic                 load_out;

    // Full is judged from registered state only, so tready never depends on m_axis_tready.
    assign full  = (fill_q == DEPTH_L);
    // A flush cancels any write or read offered in the same cycle.
    assign wr_en = s_axis_tvalid & rdy_q & ~full & ~flush;
    assign rd_en = out_valid_q & m_axis_tready & ~flush;

    // Words sitting in RAM, i.e. not yet moved into the output register.
    assign ram_cnt  = fill_q - {{mem_width{1'b0}}, out_valid_q};
    // Refill the output stage when it is empty or being consumed and RAM has data.
    assign load_out = (~out_valid_q | rd_en) & (ram_cnt != '0) & ~flush;

`ifdef AXIS_FIFO_DROP_EN
    logic        drop_en;
    logic [15:0] drop_q, drop_d;

    assign s_axis_tready = rdy_q;
    assign drop_en       = s_axis_tvalid & rdy_q & full & ~flush;
    assign drop_count    = drop_q;

    // Saturating count of writes discarded because the FIFO was full.
    always_comb begin
        drop_d = drop_q;
        if (drop_en && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // Drop counter register; only reset clears it, flush leaves it alone.
    always_ff @(posedge axis_clk or negedge rst) begin
        if (!rst) begin
            drop_q <= 16'd0;
        end else begin
            drop_q <= drop_d;
        end
    end
`else
    assign s_axis_tready = rdy_q & ~full;
    assign drop_count    = 16'd0;
`endif

    // Next-state for pointers, occupancy, output-valid and threshold flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + mem_width'(wr_en);
        rd_ptr_d    = rd_ptr_q + mem_width'(load_out);
        out_valid_d = out_valid_q;
        fill_d      = fill_q;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
            fill_d      = '0;
        end else begin
            if (load_out) begin
                out_valid_d = 1'b1;
            end else if (rd_en) begin
                out_valid_d = 1'b0;
            end

            unique case ({wr_en, rd_en})
                2'b10:   fill_d = fill_q + ONE_L;
                2'b01:   fill_d = fill_q - ONE_L;
                default: fill_d = fill_q;
            endcase
        end

        af_d = (fill_d >= af_thresh);
        ae_d = (fill_d <= ae_thresh);
    end

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge axis_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= s_axis_tdata;
        end
    end

    // Control state, registered RAM read into the output stage, and flags.
    always_ff @(posedge axis_clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            rdy_q       <= 1'b0;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            rdy_q       <= 1'b1;
            af_q        <= af_d;
            ae_q        <= ae_d;
            if (load_out) begin
                out_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;
    assign fill_level    = fill_q;
    assign almost_full   = af_q;
    assign almost_empty  = ae_q;

endmodule
